// File: rtl/nco_pkg.sv
// Shared constants, quadrant encoding and LUT entry generator
// for the NCO carrier block.
package nco_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int LUT_AW_DEF  = 3;
  localparam int AMP_W_DEF   = 3;
  localparam int ERR_W_DEF   = 16;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    Q_RISE,
    Q_FALL,
    Q_NRISE,
    Q_NFALL
  } quad_e;

  // Entry k of a full 2^aw-point sine table, rounded half away
  // from zero; evaluated only at elaboration.
  function automatic int lut_entry(
    input int k,
    input int aw,
    input int amp_w
  );
    int  n;
    int  h;
    int  q;
    int  kk;
    int  r;
    bit  neg;
    real x;
    real t;
    real s;
    real mag;
    n  = 1 << aw;
    h  = n / 2;
    q  = n / 4;
    kk = k % n;
    if (kk < 0) kk = kk + n;
    neg = (kk >= h);
    if (neg) kk = kk - h;
    if (kk > q) kk = h - kk;
    x = 6.283185307179586 * kk / n;
    s = 0.0;
    t = x;
    for (int i = 1; i <= 9; i++) begin
      s = s + t;
      t = -t * x * x / ((2 * i) * (2 * i + 1));
    end
    mag = ((1 << (amp_w - 1)) - 1) * s;
    r   = $rtoi(mag + 0.5);
    return neg ? -r : r;
  endfunction

endpackage

// File: rtl/nco_lut.sv
// Quarter-wave sine table with quadrant mirroring/negation,
// two read ports and registered outputs.
module nco_lut
  import nco_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int AMP_W  = AMP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ld,
  input  logic [LUT_AW-1:0] i_addr_a,
  input  logic [LUT_AW-1:0] i_addr_b,
  output logic [AMP_W-1:0]  o_a,
  output logic [AMP_W-1:0]  o_b
);

  localparam int Q  = 1 << (LUT_AW - 2);
  localparam int IW = LUT_AW - 1;

  logic [AMP_W-1:0]  w_tab  [Q+1];
  logic [LUT_AW-1:0] w_addr [2];
  logic [AMP_W-1:0]  w_val  [2];

  assign w_addr[0] = i_addr_a;
  assign w_addr[1] = i_addr_b;

  for (genvar i = 0; i <= Q; i++) begin : g_tab
    localparam int V = lut_entry(i, LUT_AW, AMP_W);
    assign w_tab[i] = AMP_W'(V);
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [IW-1:0]    w_low;
    logic [IW-1:0]    w_idx;
    logic [AMP_W-1:0] w_mag;
    logic             w_mir;
    logic             w_neg;

    always_comb begin
      w_mir = 1'b0;
      w_neg = 1'b0;
      unique case (quad_e'(w_addr[p][LUT_AW-1 -: 2]))
        Q_RISE:  w_mir = 1'b0;
        Q_FALL:  w_mir = 1'b1;
        Q_NRISE: w_neg = 1'b1;
        Q_NFALL: begin
          w_mir = 1'b1;
          w_neg = 1'b1;
        end
      endcase
    end

    assign w_low = {1'b0, w_addr[p][LUT_AW-3:0]};
    assign w_idx = w_mir ? (IW'(Q) - w_low) : w_low;
    assign w_mag = w_tab[w_idx];
    assign w_val[p] = w_neg ? -w_mag : w_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_a <= '0;
      o_b <= '0;
    end else if (i_ld) begin
      o_a <= w_val[0];
      o_b <= w_val[1];
    end
  end

endmodule

// File: rtl/nco_carrier.sv
// Phase-steerable NCO with quadrature LUT outputs and a
// saturating carrier-cycle counter with dump snapshots.
module nco_carrier
  import nco_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int AMP_W   = AMP_W_DEF,
  parameter int ERR_W   = ERR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PHASE_W-1:0] fcw_in,
  input  logic               fcw_load,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic [ERR_W-1:0]   phase_err,
  input  logic               dump,
  output logic [AMP_W-1:0]   sine,
  output logic [AMP_W-1:0]   cosine,
  output logic               out_valid,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [PHASE_W-1:0] phase_snap,
  output logic               snap_valid
);

  localparam int SW = PHASE_W + 2;

  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_fcw;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_cyc;
  logic [PHASE_W-1:0] r_snap;
  logic               r_snap_v;
  logic [LUT_AW-1:0]  r_sa;
  logic [LUT_AW-1:0]  r_ca;
  logic               r_v1;
  logic               r_v2;

  logic [SW-1:0]      w_sum;
  logic               w_wrap;
  logic [LUT_AW-1:0]  w_sa;
  logic [LUT_AW-1:0]  w_ca;

  assign w_sum = {2'b00, r_acc}
               + {2'b00, r_fcw}
               + {{(SW-ERR_W){phase_err[ERR_W-1]}},
                  phase_err};

  // Positive wrap only: top bit clear, carry bit set.
  assign w_wrap = en & ~w_sum[SW-1] & w_sum[PHASE_W];

  assign w_sa = LUT_AW'((r_acc + phase_offset)
                >> (PHASE_W - LUT_AW));
  assign w_ca = w_sa + LUT_AW'(1 << (LUT_AW - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_fcw <= '0;
    end else begin
      if (en) r_acc <= w_sum[PHASE_W-1:0];
      if (fcw_load) r_fcw <= fcw_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_cyc    <= '0;
      r_snap   <= '0;
      r_snap_v <= 1'b0;
    end else begin
      r_snap_v <= dump;
      if (dump) begin
        r_cyc  <= r_cnt;
        r_snap <= r_acc;
        r_cnt  <= CNT_W'(w_wrap);
      end else if (w_wrap && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sa <= '0;
      r_ca <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= en;
      r_v2 <= r_v1;
      if (en) begin
        r_sa <= w_sa;
        r_ca <= w_ca;
      end
    end
  end

  nco_lut #(
    .LUT_AW (LUT_AW),
    .AMP_W  (AMP_W)
  ) u_lut (
    .clk      (clk),
    .reset    (reset),
    .i_ld     (r_v1),
    .i_addr_a (r_sa),
    .i_addr_b (r_ca),
    .o_a      (sine),
    .o_b      (cosine)
  );

  assign out_valid  = r_v2;
  assign cyc_cnt    = r_cyc;
  assign phase_snap = r_snap;
  assign snap_valid = r_snap_v;

endmodule

// File: tb/tb_nco_carrier.sv
// Scoreboard bench for nco_carrier: randomized stimulus against
// a math-level reference model, decoupled output monitor.
module tb_nco_carrier;

  localparam int PW   = 8;
  localparam int AW   = 3;
  localparam int AMPW = 3;
  localparam int EW   = 8;
  localparam int CW   = 4;
  localparam int NPT  = 1 << AW;
  localparam int MODP = 1 << PW;
  localparam int SMOD = 1 << (PW + 2);
  localparam int CMAX = (1 << CW) - 1;

  bit            clk;
  logic          reset;
  logic          en;
  logic [PW-1:0] fcw_in;
  logic          fcw_load;
  logic [PW-1:0] phase_offset;
  logic [EW-1:0] phase_err;
  logic          dump;
  logic [AMPW-1:0] sine;
  logic [AMPW-1:0] cosine;
  logic          out_valid;
  logic [CW-1:0] cyc_cnt;
  logic [PW-1:0] phase_snap;
  logic          snap_valid;

  nco_carrier #(
    .PHASE_W (PW),
    .LUT_AW  (AW),
    .AMP_W   (AMPW),
    .ERR_W   (EW),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .fcw_in       (fcw_in),
    .fcw_load     (fcw_load),
    .phase_offset (phase_offset),
    .phase_err    (phase_err),
    .dump         (dump),
    .sine         (sine),
    .cosine       (cosine),
    .out_valid    (out_valid),
    .cyc_cnt      (cyc_cnt),
    .phase_snap   (phase_snap),
    .snap_valid   (snap_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int c;
    int t;
  } samp_t;

  typedef struct {
    int cnt;
    int ph;
    int t;
  } snap_t;

  samp_t sq[$];
  snap_t nq[$];
  samp_t es;
  snap_t en_q;
  int    got_s[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    m_acc, m_fcw, m_cnt;
  int    last_s, last_c;
  int    last_cnt, last_ph, n_snap;
  bit    mon_on = 0;
  int    snap0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  function automatic int sx(logic [AMPW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int ref_sin(int k);
    real v;
    v = real'((1 << (AMPW - 1)) - 1)
        * $sin(2.0 * 3.141592653589793 * k / NPT);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents data.
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      if (out_valid) begin
        if (sq.size() == 0) begin
          check("unexpected out_valid", 1, 0);
        end else begin
          es = sq.pop_front();
          check("sine", sx(sine), es.s);
          check("cosine", sx(cosine), es.c);
          check("sample latency", cyc, es.t);
          got_s.push_back(sx(sine));
        end
        last_s = sx(sine);
        last_c = sx(cosine);
      end else begin
        check("sine hold", sx(sine), last_s);
        check("cosine hold", sx(cosine), last_c);
      end
      if (snap_valid) begin
        n_snap++;
        last_cnt = int'(cyc_cnt);
        last_ph  = int'(phase_snap);
        if (nq.size() == 0) begin
          check("unexpected snap_valid", 1, 0);
        end else begin
          en_q = nq.pop_front();
          check("cyc_cnt", last_cnt, en_q.cnt);
          check("phase_snap", last_ph, en_q.ph);
          check("snap latency", cyc, en_q.t);
        end
      end
    end
  end

  task automatic step(bit e, bit ld, int f, int off,
                      int er, bit d);
    int s;
    int a;
    bit wrap;
    @(negedge clk);
    #1;
    en           = e;
    fcw_load     = ld;
    fcw_in       = f[PW-1:0];
    phase_offset = off[PW-1:0];
    phase_err    = er[EW-1:0];
    dump         = d;
    a = ((m_acc + off) % MODP) * NPT / MODP;
    if (e) begin
      sq.push_back('{ref_sin(a), ref_sin((a + NPT / 4) % NPT),
                     cyc + 2});
    end
    s = (((m_acc + m_fcw + er) % SMOD) + SMOD) % SMOD;
    if (s >= SMOD / 2) s = s - SMOD;
    wrap = e && (s >= MODP);
    if (d) begin
      nq.push_back('{m_cnt, m_acc, cyc + 1});
      m_cnt = wrap ? 1 : 0;
    end else if (wrap && m_cnt < CMAX) begin
      m_cnt++;
    end
    if (e) m_acc = ((s % MODP) + MODP) % MODP;
    if (ld) m_fcw = f % MODP;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset    = 1;
    en       = 1;
    fcw_load = 1;
    fcw_in   = PW'($urandom);
    dump     = 1;
    sq.delete();
    nq.delete();
    m_acc  = 0;
    m_fcw  = 0;
    m_cnt  = 0;
    last_s = 0;
    last_c = 0;
    @(negedge clk);
    #1;
    check("rst sine", sx(sine), 0);
    check("rst cosine", sx(cosine), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst snap_valid", int'(snap_valid), 0);
    check("rst cyc_cnt", int'(cyc_cnt), 0);
    check("rst phase_snap", int'(phase_snap), 0);
    reset    = 0;
    en       = 0;
    fcw_load = 0;
    dump     = 0;
    mon_on   = 1;
  endtask

  initial begin
    int exp_s[10];
    int ok;
    exp_s = '{0, 2, 3, 2, 0, -2, -3, -2, 0, 2};
    reset = 1; en = 0; fcw_load = 0; dump = 0;
    fcw_in = '0; phase_offset = '0; phase_err = '0;

    // Scenario 1: basic tone, fcw=32
    do_reset();
    step(0, 1, 32, 0, 0, 0);
    got_s.delete();
    repeat (10) step(1, 0, 0, 0, 0, 0);
    idle(3);
    check("scen1 sample count", got_s.size(), 10);
    ok = (got_s.size() >= 10);
    for (int i = 0; i < 10; i++)
      if (ok != 0) check("scen1 sine seq", got_s[i], exp_s[i]);

    // Scenario 2: dump after 17 steps
    do_reset();
    step(0, 1, 32, 0, 0, 0);
    repeat (17) step(1, 0, 0, 0, 0, 0);
    snap0 = n_snap;
    step(1, 0, 0, 0, 0, 1);
    idle(3);
    check("scen2 snap pulses", n_snap - snap0, 1);
    check("scen2 cyc_cnt", last_cnt, 2);
    check("scen2 phase_snap", last_ph, 32);

    // Scenario 3: phase error cancels fcw
    do_reset();
    step(0, 1, 32, 0, 0, 0);
    repeat (8) step(1, 0, 0, 0, -32, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    check("scen3 cnt", last_cnt, 0);
    check("scen3 acc", last_ph, 0);
    step(1, 0, 0, 0, -64, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    check("scen3 neg wrap acc", last_ph, 224);
    check("scen3 neg wrap cnt", last_cnt, 0);

    // Scenario 4: fcw load during en, then offset
    do_reset();
    step(0, 1, 32, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 64, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    check("scen4 acc", last_ph, 64);
    repeat (24) step(bit'($urandom_range(0, 1)), 0, 0, 64, 0, 0);
    idle(3);

    // Scenario 5: saturation then reset mid-stream
    do_reset();
    step(0, 1, 255, 0, 0, 0);
    repeat (40) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    check("scen5 saturated cnt", last_cnt, CMAX);
    step(0, 1, 37, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    do_reset();
    idle(2);
    repeat (6) step(1, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, MODP - 1)),
           int'($urandom_range(0, MODP - 1)),
           ($urandom_range(0, 7) == 0)
             ? int'($urandom_range(0, 255)) - 128
             : int'($urandom_range(0, 31)) - 16,
           bit'($urandom_range(0, 11) == 0));
    end
    idle(4);
    check("sample queue drained", sq.size(), 0);
    check("snap queue drained", nq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
